// File: rtl/tohost_monitor_pkg.sv
// Purpose: shared FSM state encoding for the tohost completion monitor.
// Latency: n/a (types only).
// Backpressure: n/a.
package tohost_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned CYCLES_W = 32;

endpackage

// File: rtl/tohost_channel.sv
// Purpose: one tohost channel; captures the first valid (bit0=1) write of a run.
// Latency: flags update on the edge that samples the write; next-state is exported.
// Backpressure: none; writes to an already-done channel or outside RUN are dropped.
// Ports: clk/rst (sync, active-low); clr_i clears flags at run start; run_i enables capture;
//        wr_i/dat_i are the write strobe and word; done_o/fail_o are the registered flags;
//        done_nxt_o is the flag value after this edge; cap_fail_o marks a failing capture now.
module tohost_channel
    import tohost_monitor_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  run_i,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  done_o,
    output logic                  fail_o,
    output logic                  done_nxt_o,
    output logic                  cap_fail_o
);

    logic done_q, done_d;
    logic fail_q, fail_d;
    logic cap;

    // Only the first word with bit0 set counts; later writes cannot alter the verdict.
    assign cap        = run_i & wr_i & dat_i[0] & ~done_q;
    assign cap_fail_o = cap & (|dat_i[DATA_WIDTH-1:1]);

    always_comb begin
        done_d = done_q;
        fail_d = fail_q;
        if (clr_i) begin
            done_d = 1'b0;
            fail_d = 1'b0;
        end else if (cap) begin
            done_d = 1'b1;
            fail_d = cap_fail_o;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            done_q <= done_d;
            fail_q <= fail_d;
        end
    end

    assign done_o     = done_q;
    assign fail_o     = fail_q;
    assign done_nxt_o = done_d;

endmodule

// File: rtl/tohost_monitor.sv
// Purpose: run monitor over NUM_CH tohost channels with cycle budget and pass/fail verdict.
// Latency: done rises 1 cycle after the completing write or the last budgeted RUN edge.
// Backpressure: none; start is ignored while busy, writes outside RUN are dropped.
// Ports: clk/rst (sync, active-low); start begins a run; tohost/tohost_wr carry per-channel
//        words and strobes; busy/done/pass/timeout give run status; ch_done/ch_fail are
//        per-channel flags; fail_code is the first failing code; cycles counts RUN edges.
module tohost_monitor
    import tohost_monitor_pkg::*;
#(
    parameter int          NUM_CH         = 2,
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int          REQUIRE_ALL    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUM_CH*DATA_WIDTH-1:0] tohost,
    input  logic [NUM_CH-1:0]            tohost_wr,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         timeout,
    output logic [NUM_CH-1:0]            ch_done,
    output logic [NUM_CH-1:0]            ch_fail,
    output logic [DATA_WIDTH-2:0]        fail_code,
    output logic [CYCLES_W-1:0]          cycles
);

    localparam logic [CYCLES_W-1:0] LAST_CYCLE = CYCLES_W'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [CYCLES_W-1:0]   cycles_q, cycles_d;
    logic [DATA_WIDTH-2:0] fail_code_q, fail_code_d;
    logic                  timeout_q, timeout_d;

    logic                  run;
    logic                  clr;
    logic [NUM_CH-1:0]     done_nxt;
    logic [NUM_CH-1:0]     cap_fail;
    logic [DATA_WIDTH-2:0] fail_pick;
    logic                  complete;

    assign run = (state_q == ST_RUN);
    assign clr = start & ~run;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tohost_channel #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .clr_i      (clr),
            .run_i      (run),
            .wr_i       (tohost_wr[i]),
            .dat_i      (tohost[i*DATA_WIDTH +: DATA_WIDTH]),
            .done_o     (ch_done[i]),
            .fail_o     (ch_fail[i]),
            .done_nxt_o (done_nxt[i]),
            .cap_fail_o (cap_fail[i])
        );
    end

    // Descending scan so the lowest failing channel overwrites last and wins.
    always_comb begin
        fail_pick = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cap_fail[i]) begin
                fail_pick = tohost[i*DATA_WIDTH+1 +: DATA_WIDTH-1];
            end
        end
    end

    // Uses post-edge flags so a write landing on this edge can complete the run.
    assign complete = (REQUIRE_ALL != 0) ? (&done_nxt) : (|done_nxt);

    always_comb begin
        state_d     = state_q;
        cycles_d    = cycles_q;
        fail_code_d = fail_code_q;
        timeout_d   = timeout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    cycles_d    = '0;
                    fail_code_d = '0;
                    timeout_d   = 1'b0;
                end
            end
            ST_RUN: begin
                cycles_d = cycles_q + 1'b1;
                // Registered ch_fail clear means no failure has been recorded yet this run.
                if ((|cap_fail) && (ch_fail == '0)) begin
                    fail_code_d = fail_pick;
                end
                if (complete) begin
                    state_d = ST_DONE;
                end else if (cycles_q == LAST_CYCLE) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cycles_q    <= '0;
            fail_code_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycles_q    <= cycles_d;
            fail_code_q <= fail_code_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy      = run;
    assign done      = (state_q == ST_DONE);
    assign timeout   = timeout_q;
    assign fail_code = fail_code_q;
    assign cycles    = cycles_q;
    assign pass      = done & ~timeout_q & (ch_fail == '0);

endmodule
